// File: rtl/complement2_seq.sv
// Multi-cycle two's-complement unit: pass, negate, abs and negative-abs of an N-bit operand.
// The operand is processed W bits per cycle, LSB chunk first, with the carry held between chunks.
module complement2_seq #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         overflow
);

  localparam int K  = N / W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  generate
    if (N < 2 || W < 1 || W > N || (N % W) != 0) begin : g_bad_params
      $error("complement2_seq: need N >= 2, 1 <= W <= N and N a multiple of W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    shift_q, shift_d;
  logic [N-1:0]    out_q, out_d;
  logic            inv_q, inv_d;
  logic            ovf_q, ovf_d;
  logic            carry_q, carry_d;
  logic            out_valid_q, out_valid_d;
  logic            overflow_q, overflow_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept_inv;
  logic [W-1:0]    chunk;
  logic [W:0]      sum;
  logic [N-1:0]    sum_ext;
  logic [N-1:0]    shifted;

  // The shift register drains the operand from the bottom while result chunks
  // enter at the top, so after K steps it holds the complete result in place.
  always_comb begin
    accept_inv = 1'b0;
    case (mode)
      2'b00:   accept_inv = 1'b0;
      2'b01:   accept_inv = 1'b1;
      2'b10:   accept_inv = in[N-1];
      default: accept_inv = ~in[N-1];
    endcase

    chunk   = shift_q[W-1:0];
    sum     = {1'b0, (inv_q ? ~chunk : chunk)} + {{W{1'b0}}, carry_q};
    sum_ext = N'(sum[W-1:0]);
    shifted = (shift_q >> W) | (sum_ext << (N - W));

    state_d     = state_q;
    shift_d     = shift_q;
    out_d       = out_q;
    inv_d       = inv_q;
    ovf_d       = ovf_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in;
          inv_d   = accept_inv;
          ovf_d   = accept_inv && (in == MIN_VAL);
          carry_d = accept_inv;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        shift_d = shifted;
        carry_d = sum[W];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(K - 1)) begin
          out_d       = shifted;
          overflow_d  = ovf_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      out_q       <= '0;
      inv_q       <= 1'b0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      out_q       <= out_d;
      inv_q       <= inv_d;
      ovf_q       <= ovf_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_complement2_seq.sv
// Randomised and directed bench for complement2_seq at three parameter points,
// checked against a signed-arithmetic reference model.
module tb_complement2_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_s  [3];
  logic        in_ready_s  [3];
  logic [31:0] in_s        [3];
  logic [1:0]  mode_s      [3];
  logic        out_valid_s [3];
  logic        out_ready_s [3];
  logic [31:0] out_s       [3];
  logic        overflow_s  [3];
  logic [7:0]  out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  complement2_seq #(.N(32), .W(8)) u_main (
    .clk(clk), .reset(reset), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .in(in_s[0]), .mode(mode_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .out(out_s[0]), .overflow(overflow_s[0]));

  complement2_seq #(.N(32), .W(32)) u_wide (
    .clk(clk), .reset(reset), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .in(in_s[1]), .mode(mode_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .out(out_s[1]), .overflow(overflow_s[1]));

  complement2_seq #(.N(8), .W(1)) u_bit (
    .clk(clk), .reset(reset), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .in(in_s[2][7:0]), .mode(mode_s[2]), .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
    .out(out_b), .overflow(overflow_s[2]));

  assign out_s[2] = {24'd0, out_b};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: interpret the operand as a signed n-bit number, apply the mode
  // with ordinary integer arithmetic, then wrap and flag out-of-range results.
  function automatic void model(input int n, input logic [31:0] v, input logic [1:0] md,
                                output logic [31:0] r, output logic ov);
    longint lim, s, res;
    logic [31:0] mask;
    mask = (n == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    lim  = longint'(1) << (n - 1);
    s    = longint'(v & mask);
    if (v[n-1]) s = s - (lim << 1);
    case (md)
      2'b00:   res = s;
      2'b01:   res = -s;
      2'b10:   res = (s < 0) ? -s : s;
      default: res = (s < 0) ? s : -s;
    endcase
    ov = (res >= lim) || (res < -lim);
    r  = 32'(res) & mask;
  endfunction

  // Offer one operand, time the result, optionally stall the consumer while a
  // competing operand 0x7 is offered, then release. With hold > 0 in_valid is
  // left high carrying 0x7 so the caller can show it is accepted only afterwards.
  task automatic applyStimulus(input int sel, input logic [31:0] val, input logic [1:0] md,
                               input int hold);
    int n, k, edges, waitCnt;
    logic [31:0] expOut, mask;
    logic expOv;
    n    = (sel == 2) ? 8 : 32;
    k    = (sel == 0) ? 4 : ((sel == 1) ? 1 : 8);
    mask = (n == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    model(n, val, md, expOut, expOv);

    waitCnt = 0;
    while (in_ready_s[sel] !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("in_ready_before_accept", 32'(in_ready_s[sel]), 32'd1);
    in_valid_s[sel] = 1'b1;
    in_s[sel]       = val & mask;
    mode_s[sel]     = md;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[sel] = 1'b0;
    in_s[sel]       = $urandom;
    mode_s[sel]     = 2'($urandom);
    checkOutput("in_ready_after_accept", 32'(in_ready_s[sel]), 32'd0);

    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (out_valid_s[sel] === 1'b1) break;
    end
    checkOutput("latency", 32'(edges), 32'(k));
    checkOutput("result", out_s[sel], expOut);
    checkOutput("overflow", 32'(overflow_s[sel]), 32'(expOv));

    for (int i = 0; i < hold; i++) begin
      in_valid_s[sel] = 1'b1;
      in_s[sel]       = 32'h7;
      mode_s[sel]     = 2'b01;
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_out_valid", 32'(out_valid_s[sel]), 32'd1);
      checkOutput("hold_result", out_s[sel], expOut);
      checkOutput("hold_overflow", 32'(overflow_s[sel]), 32'(expOv));
      checkOutput("hold_in_ready", 32'(in_ready_s[sel]), 32'd0);
    end

    out_ready_s[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_s[sel] = 1'b0;
    checkOutput("release_out_valid", 32'(out_valid_s[sel]), 32'd0);
    checkOutput("release_in_ready", 32'(in_ready_s[sel]), 32'd1);
    checkOutput("release_result_kept", out_s[sel], expOut);
  endtask

  logic [31:0] rval;
  logic [1:0]  rmode;
  int          rhold, rsel;

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid_s[i]  = 1'b0;
      in_s[i]        = '0;
      mode_s[i]      = 2'b00;
      out_ready_s[i] = 1'b0;
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("reset_out", out_s[i], 32'd0);
      checkOutput("reset_out_valid", 32'(out_valid_s[i]), 32'd0);
      checkOutput("reset_overflow", 32'(overflow_s[i]), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready_s[i]), 32'd1);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(0, 32'h0000_0001, 2'b01, 0);
    applyStimulus(0, 32'h0000_0100, 2'b01, 0);
    applyStimulus(0, 32'h0000_0000, 2'b01, 0);
    applyStimulus(0, 32'h8000_0000, 2'b01, 0);
    applyStimulus(0, 32'hFFFF_FFF6, 2'b10, 0);
    applyStimulus(0, 32'h0000_0005, 2'b10, 0);
    applyStimulus(0, 32'h0000_0005, 2'b11, 0);
    applyStimulus(0, 32'h8000_0000, 2'b11, 0);
    applyStimulus(0, 32'h1234_5678, 2'b00, 0);

    applyStimulus(0, 32'h0000_00FF, 2'b01, 3);
    applyStimulus(0, 32'h0000_0007, 2'b01, 0);

    // Abort a conversion two edges into BUSY; outputs must clear with no clock.
    in_valid_s[0] = 1'b1;
    in_s[0]       = 32'h0001_2345;
    mode_s[0]     = 2'b01;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_out", out_s[0], 32'd0);
    checkOutput("abort_out_valid", 32'(out_valid_s[0]), 32'd0);
    checkOutput("abort_overflow", 32'(overflow_s[0]), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready_s[0]), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(0, 32'h0000_0002, 2'b01, 0);

    applyStimulus(1, 32'h0000_0003, 2'b01, 0);
    applyStimulus(1, 32'h8000_0000, 2'b10, 1);
    applyStimulus(1, 32'h0000_0007, 2'b01, 0);
    applyStimulus(2, 32'h0000_0080, 2'b10, 0);
    applyStimulus(2, 32'h0000_0080, 2'b11, 0);
    applyStimulus(2, 32'h0000_0001, 2'b01, 0);

    for (int t = 0; t < 60; t++) begin
      rsel  = int'($urandom_range(0, 2));
      rmode = 2'($urandom);
      case ($urandom_range(0, 7))
        0:       rval = (rsel == 2) ? 32'h80 : 32'h8000_0000;
        1:       rval = 32'd0;
        default: rval = $urandom;
      endcase
      rhold = int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(1, 2)) : 0;
      applyStimulus(rsel, rval, rmode, rhold);
      if (rhold > 0) applyStimulus(rsel, 32'h0000_0007, 2'b01, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
